// File: rtl/alu_sweep_pkg.sv
// Shared definitions for the exhaustive ALU sweep detector: opcodes, FSM states
// and the golden ALU reference used to judge every DUT result.
package alu_sweep_pkg;

    localparam int GOLD_W = 32;

    localparam logic [7:0] OP_ADD = 8'd0;
    localparam logic [7:0] OP_SUB = 8'd1;
    localparam logic [7:0] OP_AND = 8'd2;
    localparam logic [7:0] OP_OR  = 8'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sweep_state_e;

    // Result is masked to 'width' bits so callers can cast down without carries leaking in.
    function automatic logic [GOLD_W-1:0] golden_alu(
        input logic [GOLD_W-1:0] a,
        input logic [GOLD_W-1:0] b,
        input logic [7:0]        op,
        input int                width
    );
        logic [GOLD_W-1:0] r;
        logic [GOLD_W-1:0] mask;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            default: r = '0;
        endcase
        if (width >= GOLD_W) begin
            mask = '1;
        end else begin
            mask = ~({GOLD_W{1'b1}} << width);
        end
        return r & mask;
    endfunction

endpackage

// File: rtl/alu_sweep_expq.sv
// Expected-value delay line that lines up each issued vector with the DUT result
// arriving LAT cycles later; collapses to plain wires for a combinational DUT.
module alu_sweep_expq
    import alu_sweep_pkg::*;
#(
    parameter int LAT = 0,
    parameter int DW  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    generate
        if (LAT == 0) begin : g_wire
            assign out_valid = in_valid;
            assign out_data  = in_data;

            logic unused_ok;
            assign unused_ok = ^{clk, rst_n, flush};
        end else begin : g_pipe
            logic [LAT-1:0]         valid_q;
            logic [LAT-1:0][DW-1:0] data_q;

            // Stage 0 is the newest entry; the top stage feeds the comparator.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= '0;
                    data_q  <= '0;
                end else begin
                    valid_q <= flush ? '0 : LAT'({valid_q, in_valid});
                    data_q  <= (LAT*DW)'({data_q, in_data});
                end
            end

            assign out_valid = valid_q[LAT-1];
            assign out_data  = data_q[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/alu_sweep_detector.sv
// Walks every {op, A, B} through an external ALU, checks each result against the
// golden model, counts mismatches and keeps the first failing vector.
module alu_sweep_detector
    import alu_sweep_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int OP_W    = 2,
    parameter int DUT_LAT = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort_on_fail,
    output logic [WIDTH-1:0]          stim_a,
    output logic [WIDTH-1:0]          stim_b,
    output logic [OP_W-1:0]           stim_op,
    output logic                      stim_valid,
    input  logic [WIDTH-1:0]          dut_result,
    output logic                      busy,
    output logic                      done,
    output logic [2*WIDTH+OP_W:0]     mismatch_cnt,
    output logic                      trojan_flag,
    output logic                      ff_valid,
    output logic [WIDTH-1:0]          ff_a,
    output logic [WIDTH-1:0]          ff_b,
    output logic [OP_W-1:0]           ff_op,
    output logic [WIDTH-1:0]          ff_exp,
    output logic [WIDTH-1:0]          ff_got
);

    localparam int VW = 2*WIDTH + OP_W;
    localparam int CW = VW + 1;
    localparam int DW = OP_W + 3*WIDTH;

    localparam logic [VW-1:0] VEC_LAST   = '1;
    localparam logic [CW-1:0] CNT_MAX    = '1;
    localparam logic [3:0]    DRAIN_LAST = (DUT_LAT > 0) ? 4'(DUT_LAT - 1) : 4'd0;

    sweep_state_e     state_q;
    logic [VW-1:0]    vec_q;
    logic [3:0]       drain_q;
    logic             armed_q;
    logic             abort_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             ff_valid_q;
    logic [WIDTH-1:0] ff_a_q;
    logic [WIDTH-1:0] ff_b_q;
    logic [OP_W-1:0]  ff_op_q;
    logic [WIDTH-1:0] ff_exp_q;
    logic [WIDTH-1:0] ff_got_q;

    logic [OP_W-1:0]  vec_op;
    logic [WIDTH-1:0] vec_a;
    logic [WIDTH-1:0] vec_b;
    logic [WIDTH-1:0] vec_exp;

    assign vec_op  = vec_q[VW-1 -: OP_W];
    assign vec_a   = vec_q[2*WIDTH-1 -: WIDTH];
    assign vec_b   = vec_q[WIDTH-1:0];
    assign vec_exp = WIDTH'(golden_alu(GOLD_W'(vec_a), GOLD_W'(vec_b), 8'(vec_op), WIDTH));

    logic             pipe_valid;
    logic [DW-1:0]    pipe_data;
    logic [OP_W-1:0]  cmp_op;
    logic [WIDTH-1:0] cmp_a;
    logic [WIDTH-1:0] cmp_b;
    logic [WIDTH-1:0] cmp_exp;
    logic             hit;
    logic             abort_hit;
    logic             start_ok;
    logic             flush;

    // armed_q blocks a start seen on the very first edge after reset release.
    assign start_ok  = start && armed_q && (state_q == IDLE || state_q == DONE);
    assign hit       = pipe_valid && (dut_result != cmp_exp);
    assign abort_hit = hit && abort_q;
    assign flush     = start_ok || abort_hit;
    assign cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    assign {cmp_op, cmp_a, cmp_b, cmp_exp} = pipe_data;

    alu_sweep_expq #(
        .LAT (DUT_LAT),
        .DW  (DW)
    ) u_expq (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (stim_valid),
        .in_data   ({vec_op, vec_a, vec_b, vec_exp}),
        .out_valid (pipe_valid),
        .out_data  (pipe_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            vec_q      <= '0;
            drain_q    <= '0;
            armed_q    <= 1'b0;
            abort_q    <= 1'b0;
            cnt_q      <= '0;
            ff_valid_q <= 1'b0;
            ff_a_q     <= '0;
            ff_b_q     <= '0;
            ff_op_q    <= '0;
            ff_exp_q   <= '0;
            ff_got_q   <= '0;
        end else begin
            armed_q <= 1'b1;

            if (hit) begin
                cnt_q <= cnt_d;
                if (!ff_valid_q) begin
                    ff_valid_q <= 1'b1;
                    ff_a_q     <= cmp_a;
                    ff_b_q     <= cmp_b;
                    ff_op_q    <= cmp_op;
                    ff_exp_q   <= cmp_exp;
                    ff_got_q   <= dut_result;
                end
            end

            case (state_q)
                IDLE, DONE: begin
                    if (start_ok) begin
                        state_q    <= RUN;
                        vec_q      <= '0;
                        drain_q    <= '0;
                        abort_q    <= abort_on_fail;
                        cnt_q      <= '0;
                        ff_valid_q <= 1'b0;
                        ff_a_q     <= '0;
                        ff_b_q     <= '0;
                        ff_op_q    <= '0;
                        ff_exp_q   <= '0;
                        ff_got_q   <= '0;
                    end
                end
                RUN: begin
                    // The counter parks on the last vector so DRAIN keeps presenting it.
                    if (abort_hit) begin
                        state_q <= DONE;
                    end else if (vec_q == VEC_LAST) begin
                        state_q <= (DUT_LAT == 0) ? DONE : DRAIN;
                        drain_q <= '0;
                    end else begin
                        vec_q <= vec_q + VW'(1);
                    end
                end
                DRAIN: begin
                    if (abort_hit || drain_q == DRAIN_LAST) begin
                        state_q <= DONE;
                    end else begin
                        drain_q <= drain_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stim_op      = vec_op;
    assign stim_a       = vec_a;
    assign stim_b       = vec_b;
    assign stim_valid   = (state_q == RUN);
    assign busy         = (state_q == RUN) || (state_q == DRAIN);
    assign done         = (state_q == DONE);
    assign mismatch_cnt = cnt_q;
    assign trojan_flag  = |cnt_q;
    assign ff_valid     = ff_valid_q;
    assign ff_a         = ff_a_q;
    assign ff_b         = ff_b_q;
    assign ff_op        = ff_op_q;
    assign ff_exp       = ff_exp_q;
    assign ff_got       = ff_got_q;

endmodule
